ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_rr_picker.sv | 25 ++
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the image byte RAM arbiter: data/address widths,
// the arbiter state encoding and small elaboration-time helpers.
package ram_arbiter_pkg;

   // Image RAM geometry shared by every requester.
   localparam int BYTE_WIDTH = 8;
   localparam int ADDR_WIDTH = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // Width of an index into n requesters (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Round-robin picker: one-hot winner is the first set req bit at or after
// ptr, searching upward and wrapping modulo NUM_REQ. Purely combinational.
module rr_picker
   import ram_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner
);

   // Scan from the farthest candidate back to ptr so the closest hit wins.
   always_comb begin
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            winner = '0;
            winner[(int'(ptr) + k) % NUM_REQ] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one image byte RAM between NUM_REQ requesters.
// A grant is a lock held while req stays high; handover is zero-bubble and an
// optional hold limit revokes a long grant when someone else is waiting.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               req_ren,
   input  logic [NUM_REQ-1:0]               req_wen,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*BYTE_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               rdata_valid,
   output logic [BYTE_WIDTH-1:0]            rdata,
   output logic                             RAM_ren,
   output logic                             RAM_wen,
   output logic [ADDR_WIDTH-1:0]            RAM_addr,
   output logic [BYTE_WIDTH-1:0]            RAM_in,
   input  logic [BYTE_WIDTH-1:0]            RAM_out,
   output logic                             busy
);

   localparam int IDX_W  = idx_width(NUM_REQ);
   localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   arb_state_t         state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   nxt_idx;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   pick_ptr;
   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] winner;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [HOLD_W-1:0]  hold_inc;
   logic               holder_drop;
   logic               hold_expired;

   // Saturating increment: the hold counter sticks at MAX_HOLD, never wraps.
   function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
      return (v >= HOLD_MAX) ? HOLD_MAX : v + 1'b1;
   endfunction

   // Candidates exclude the current holder; while granted, the search starts
   // just past the holder, which is where ptr lands once the grant ends.
   assign nxt_idx  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   assign pick_req = req & ~gnt;
   assign pick_ptr = (state == ST_GRANT) ? nxt_idx : ptr;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (pick_req),
      .ptr    (pick_ptr),
      .winner (winner)
   );

   // Encode the one-hot winner into an index for the data muxes.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) win_idx = IDX_W'(i);
      end
   end

   // The current cycle counts toward the hold; revoke once it reaches the limit.
   assign hold_inc     = sat_inc(hold_cnt);
   assign holder_drop  = ~req[gnt_idx];
   assign hold_expired = (MAX_HOLD != 0) && (hold_inc >= HOLD_MAX) && (|pick_req);

   // Arbiter FSM: grant, handover, revocation and round-robin pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         gnt_idx  <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (|req) begin
            state    <= ST_GRANT;
            gnt      <= winner;
            gnt_idx  <= win_idx;
            hold_cnt <= '0;
         end
      end else begin
         if (holder_drop || hold_expired) begin
            ptr      <= nxt_idx;
            hold_cnt <= '0;
            if (|pick_req) begin
               gnt     <= winner;
               gnt_idx <= win_idx;
            end else begin
               state <= ST_IDLE;
               gnt   <= '0;
            end
         end else begin
            hold_cnt <= hold_inc;
         end
      end
   end

   // Route the holder's strobes, address and data to the RAM; write beats read.
   always_comb begin
      RAM_ren  = 1'b0;
      RAM_wen  = 1'b0;
      RAM_addr = '0;
      RAM_in   = '0;
      if (state == ST_GRANT) begin
         RAM_wen  = req_wen[gnt_idx];
         RAM_ren  = req_ren[gnt_idx] & ~req_wen[gnt_idx];
         RAM_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         RAM_in   = req_wdata[int'(gnt_idx)*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // ---- read return stage: tag the RAM_out cycle with the reading requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_valid <= '0;
      else        rdata_valid <= RAM_ren ? gnt : '0;
   end

   assign rdata = RAM_out;
   assign busy  = |gnt;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios for the key
// behaviours followed by randomized traffic, all compared every cycle
// against a behavioural round-robin lock model.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int MH = 8;
   localparam int AW = ADDR_WIDTH;
   localparam int BW = BYTE_WIDTH;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, req_ren, req_wen;
   logic [N*AW-1:0] req_addr;
   logic [N*BW-1:0] req_wdata;
   logic [N-1:0]    gnt, rdata_valid;
   logic [BW-1:0]   rdata, RAM_in, RAM_out;
   logic            RAM_ren, RAM_wen, busy;
   logic [AW-1:0]   RAM_addr;

   ram_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_ren     (req_ren),
      .req_wen     (req_wen),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .rdata_valid (rdata_valid),
      .rdata       (rdata),
      .RAM_ren     (RAM_ren),
      .RAM_wen     (RAM_wen),
      .RAM_addr    (RAM_addr),
      .RAM_in      (RAM_in),
      .RAM_out     (RAM_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who holds the RAM (-1 none), where the next search
   // starts, how many cycles the holder has used, who gets read data next.
   int m_holder, m_ptr, m_cnt, m_rv;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
      m_rv     = -1;
   endtask

   // First pending requester at or after start (wrapping), skipping excl.
   function automatic int first_from(input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (req[j] && j != excl) return j;
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_step();
      int h, c, w;
      if (!rst_n) begin
         model_reset();
         return;
      end
      h = m_holder;
      m_rv = (h >= 0 && req_ren[h] && !req_wen[h]) ? h : -1;
      if (h < 0) begin
         if (req != '0) begin
            m_holder = first_from(m_ptr, -1);
            m_cnt    = 0;
         end
      end else begin
         c = (m_cnt + 1 > MH) ? MH : m_cnt + 1;
         w = first_from((h + 1) % N, h);
         if (!req[h] || (MH != 0 && c >= MH && w >= 0)) begin
            m_ptr    = (h + 1) % N;
            m_holder = w;
            m_cnt    = 0;
         end else begin
            m_cnt = c;
         end
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0]  eg, erv;
      logic          ewen, eren;
      logic [AW-1:0] eaddr;
      logic [BW-1:0] ein;
      eg = '0; erv = '0; ewen = 1'b0; eren = 1'b0; eaddr = '0; ein = '0;
      if (m_holder >= 0) begin
         eg[m_holder] = 1'b1;
         ewen  = req_wen[m_holder];
         eren  = req_ren[m_holder] & ~req_wen[m_holder];
         eaddr = req_addr[m_holder*AW +: AW];
         ein   = req_wdata[m_holder*BW +: BW];
      end
      if (m_rv >= 0) erv[m_rv] = 1'b1;
      chk("gnt",         32'(gnt),         32'(eg));
      chk("busy",        32'(busy),        32'(m_holder >= 0));
      chk("rdata_valid", 32'(rdata_valid), 32'(erv));
      chk("RAM_wen",     32'(RAM_wen),     32'(ewen));
      chk("RAM_ren",     32'(RAM_ren),     32'(eren));
      chk("RAM_addr",    32'(RAM_addr),    32'(eaddr));
      chk("RAM_in",      32'(RAM_in),      32'(ein));
      chk("rdata",       32'(rdata),       32'(RAM_out));
   endtask

   // One clock: settle, compare, take the edge, update the model.
   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; req_ren = '0; req_wen = '0;
      model_reset();
      cycle();
      rst_n = 1'b1;
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      int order[$];
      int exp_order[5];
      int held, idle_cnt, cnt;
      logic [N-1:0] prev_gnt;

      rst_n = 1'b0;
      req = '0; req_ren = '0; req_wen = '0;
      req_addr = '0; req_wdata = '0; RAM_out = '0;
      model_reset();
      @(posedge clk);
      #1;
      repeat (2) cycle();
      chk("rst_gnt",  32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rv",   32'(rdata_valid), 32'd0);

      // Single requester: latency-1 grant, address routed.
      rst_n = 1'b1;
      cycle();
      req = 4'b0001;
      req_addr[0 +: AW] = 16'h1234;
      cycle();
      chk("r36_gnt",  32'(gnt), 32'h1);
      chk("r36_busy", 32'(busy), 32'h1);
      chk("r36_addr", 32'(RAM_addr), 32'h1234);
      cycle();

      // Everyone requesting, holder drops after 3 cycles: order 0,1,2,3,0.
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      held = 0; idle_cnt = 0; prev_gnt = '0;
      for (int c = 0; c < 40 && order.size() < 5; c++) begin
         req = 4'b1111;
         if (m_holder >= 0 && held >= 3) req[m_holder] = 1'b0;
         cycle();
         if (gnt != prev_gnt && gnt != '0) begin
            order.push_back(onehot_idx(gnt));
            held = 1;
         end else begin
            held++;
         end
         if (order.size() > 0 && gnt == '0) idle_cnt++;
         prev_gnt = gnt;
      end
      chk("r37_len",  32'(order.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < order.size()) chk("r37_order", 32'(order[i]), 32'(exp_order[i]));
      chk("r37_idle", 32'(idle_cnt), 32'd0);

      // Read by requester 2 returns tagged data one cycle later.
      do_reset();
      req = 4'b0100;
      cycle();
      chk("r38_gnt", 32'(gnt), 32'h4);
      req_ren[2] = 1'b1;
      req_addr[2*AW +: AW] = 16'd54;
      #1;
      chk("r38_addr", 32'(RAM_addr), 32'd54);
      chk("r38_ren",  32'(RAM_ren), 32'd1);
      cycle();
      req_ren[2] = 1'b0;
      RAM_out = 8'hA5;
      #1;
      chk("r38_rv",    32'(rdata_valid), 32'h4);
      chk("r38_rdata", 32'(rdata), 32'hA5);
      cycle();
      cycle();

      // Hold limit with a waiter, and unlimited hold without one.
      do_reset();
      req = 4'b0011;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         cycle();
         if (gnt == 4'b0010) break;
         if (gnt == 4'b0001) cnt++;
      end
      chk("r39_switch", 32'(gnt), 32'h2);
      chk("r39_hold",   32'(cnt), 32'd8);
      do_reset();
      req = 4'b0001;
      repeat (20) cycle();
      chk("r39_keep", 32'(gnt), 32'h1);

      // Write beats read; non-granted strobes are ignored.
      do_reset();
      req = 4'b1001;
      cycle();
      req_ren[0] = 1'b1;
      req_wen[0] = 1'b1;
      #1;
      chk("r40_wen", 32'(RAM_wen), 32'd1);
      chk("r40_ren", 32'(RAM_ren), 32'd0);
      cycle();
      req_ren = '0;
      req_wen = 4'b1000;
      #1;
      chk("r40_ngwen", 32'(RAM_wen), 32'd0);
      cycle();

      // Asynchronous reset in the middle of a write burst.
      do_reset();
      req = 4'b0001;
      req_wen = 4'b0001;
      cycle();
      cycle();
      chk("r41_pre", 32'(RAM_wen), 32'd1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("r41_wen",  32'(RAM_wen), 32'd0);
      chk("r41_gnt",  32'(gnt), 32'd0);
      chk("r41_busy", 32'(busy), 32'd0);
      cycle();
      cycle();
      rst_n = 1'b1;
      req = 4'b1010;
      req_wen = '0;
      cycle();
      chk("r41_regnt", 32'(gnt), 32'h2);

      // Randomized traffic with occasional resets.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(7) == 0) req[i] = ~req[i];
         req_ren   = N'($urandom());
         req_wen   = N'($urandom() & $urandom());
         req_addr  = {$urandom(), $urandom()};
         req_wdata = $urandom();
         RAM_out   = BW'($urandom());
         if ($urandom_range(199) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
